// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the feature-map memory port.
// Holds the two-phase memory-cycle state encodings, the default address
// width and the address constants used by the engines and the port arbiter.
package cnn_mem_pkg;

    localparam int MEMORY_STATE_BIT_WIDTH = 4;
    localparam int ADDRESS_BUS_BIT_WIDTH  = 32;

    localparam logic [ADDRESS_BUS_BIT_WIDTH-1:0] ADDRESS_OFFSET_ONE = 32'h0000_0001;
    localparam logic [ADDRESS_BUS_BIT_WIDTH-1:0] RESET_ADDRESS      = 32'h0000_0000;

    // Every memory access is IDLE -> PHASE_0 -> PHASE_1.
    typedef enum logic [MEMORY_STATE_BIT_WIDTH-1:0] {
        IDLE    = 4'd0,
        PHASE_0 = 4'd1,
        PHASE_1 = 4'd2
    } mem_state_t;

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bundle between the layer engines (master side) and the memory port
// arbiter (slave side).
//   req_i / req_wr_i / req_address_i : per-requester request, direction, address
//   grant_o / done_o                 : one-hot owner and end-of-access pulse
//   mem_rd_en_o / mem_wr_en_o        : memory enables
//   address_o / busy_o               : memory address, access in progress
interface memory_port_arbiter_if #(
    parameter int NUM_REQ               = 4,
    parameter int ADDRESS_BUS_BIT_WIDTH = cnn_mem_pkg::ADDRESS_BUS_BIT_WIDTH
);
    logic [NUM_REQ-1:0]                       req_i;
    logic [NUM_REQ-1:0]                       req_wr_i;
    logic [NUM_REQ*ADDRESS_BUS_BIT_WIDTH-1:0] req_address_i;
    logic [NUM_REQ-1:0]                       grant_o;
    logic [NUM_REQ-1:0]                       done_o;
    logic                                     mem_rd_en_o;
    logic                                     mem_wr_en_o;
    logic [ADDRESS_BUS_BIT_WIDTH-1:0]         address_o;
    logic                                     busy_o;

    // Arbiter side.
    modport slave (
        input  req_i, req_wr_i, req_address_i,
        output grant_o, done_o, mem_rd_en_o, mem_wr_en_o, address_o, busy_o
    );

    // Requester / engine side.
    modport master (
        output req_i, req_wr_i, req_address_i,
        input  grant_o, done_o, mem_rd_en_o, mem_wr_en_o, address_o, busy_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req           : request vector
//   mask          : requesters excluded from this round
//   ptr           : first requester id to consider (search goes upward, wrapping)
//   winner_onehot : one-hot winner (all zero when nothing eligible)
//   winner_id     : binary id of the winner (0 when nothing eligible)
//   any_valid     : at least one eligible request
module rr_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int REQ_ID_BIT_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          mask,
    input  logic [REQ_ID_BIT_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]          winner_onehot,
    output logic [REQ_ID_BIT_WIDTH-1:0] winner_id,
    output logic                        any_valid
);
    logic [NUM_REQ-1:0]          eligible;
    logic [NUM_REQ-1:0]          rotated;
    logic [NUM_REQ-1:0]          rot_win;
    logic [REQ_ID_BIT_WIDTH-1:0] id_acc [NUM_REQ];

    assign eligible  = req & ~mask;
    assign any_valid = |eligible;

    // Rotate so that requester ptr sits at bit 0; a fixed low-first priority
    // on the rotated vector is then the round-robin order.
    assign rotated = NUM_REQ'({eligible, eligible} >> ptr);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign rot_win[gi] = rotated[gi];
            end else begin : g_rest
                assign rot_win[gi] = rotated[gi] & ~(|rotated[gi-1:0]);
            end
        end
    endgenerate

    // Rotate the single winning bit back into requester positions.
    assign winner_onehot = NUM_REQ'(({rot_win, rot_win} << ptr) >> NUM_REQ);

    // One-hot to binary as an OR chain.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_enc
            if (gi == 0) begin : g_first
                assign id_acc[gi] = '0;
            end else begin : g_rest
                assign id_acc[gi] = id_acc[gi-1] |
                    (winner_onehot[gi] ? REQ_ID_BIT_WIDTH'(gi) : '0);
            end
        end
    endgenerate

    assign winner_id = id_acc[NUM_REQ-1];

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing the single feature-map memory port between
// NUM_REQ requesters. Each access is a two-phase cycle (PHASE_0, PHASE_1)
// carrying the owner's latched address and direction; owners follow each
// other back-to-back with no idle cycle.
//   clk         : rising-edge clock
//   layer_reset : synchronous active-high reset, aborts any access
//   bus         : requests in, grant/done/memory enables/address/busy out
// All outputs come from registers or are decoded from state registers only.
module memory_port_arbiter #(
    parameter int NUM_REQ                = 4,
    parameter int REQ_ID_BIT_WIDTH       = 2,
    parameter int ADDRESS_BUS_BIT_WIDTH  = cnn_mem_pkg::ADDRESS_BUS_BIT_WIDTH,
    parameter int MEMORY_STATE_BIT_WIDTH = cnn_mem_pkg::MEMORY_STATE_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 layer_reset,
    memory_port_arbiter_if.slave bus
);
    import cnn_mem_pkg::*;

    localparam logic [REQ_ID_BIT_WIDTH-1:0] LAST_ID = REQ_ID_BIT_WIDTH'(NUM_REQ - 1);
    localparam logic [REQ_ID_BIT_WIDTH-1:0] ID_ONE  = REQ_ID_BIT_WIDTH'(1);

    logic [MEMORY_STATE_BIT_WIDTH-1:0] state_reg, state_next;
    logic [REQ_ID_BIT_WIDTH-1:0]       owner_id_reg, owner_id_next;
    logic                              owner_wr_reg, owner_wr_next;
    logic [ADDRESS_BUS_BIT_WIDTH-1:0]  owner_addr_reg, owner_addr_next;
    logic [REQ_ID_BIT_WIDTH-1:0]       rr_ptr_reg, rr_ptr_next;

    logic [NUM_REQ-1:0]                owner_onehot;
    logic [NUM_REQ-1:0]                arb_mask;
    logic [NUM_REQ-1:0]                winner_onehot;
    logic [REQ_ID_BIT_WIDTH-1:0]       winner_id;
    logic                              any_valid;
    logic                              take_grant;
    logic                              in_access;
    logic                              winner_wr;
    logic [ADDRESS_BUS_BIT_WIDTH-1:0]  addr_acc [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner
            assign owner_onehot[gi] = (owner_id_reg == REQ_ID_BIT_WIDTH'(gi));
        end

        // AND-OR mux of the winner's address out of the packed bus.
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            if (gi == 0) begin : g_first
                assign addr_acc[gi] = {ADDRESS_BUS_BIT_WIDTH{winner_onehot[gi]}} &
                    bus.req_address_i[gi*ADDRESS_BUS_BIT_WIDTH +: ADDRESS_BUS_BIT_WIDTH];
            end else begin : g_rest
                assign addr_acc[gi] = addr_acc[gi-1] |
                    ({ADDRESS_BUS_BIT_WIDTH{winner_onehot[gi]}} &
                     bus.req_address_i[gi*ADDRESS_BUS_BIT_WIDTH +: ADDRESS_BUS_BIT_WIDTH]);
            end
        end
    endgenerate

    assign winner_wr = |(bus.req_wr_i & winner_onehot);

    // The re-arbitration in PHASE_1 excludes the current owner so a requester
    // that keeps req_i high cannot take the port twice in a row while others wait.
    assign arb_mask = (state_reg == PHASE_1) ? owner_onehot : '0;

    rr_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .REQ_ID_BIT_WIDTH (REQ_ID_BIT_WIDTH)
    ) u_rr_arbiter (
        .req           (bus.req_i),
        .mask          (arb_mask),
        .ptr           (rr_ptr_reg),
        .winner_onehot (winner_onehot),
        .winner_id     (winner_id),
        .any_valid     (any_valid)
    );

    always_ff @(posedge clk) begin
        if (layer_reset) begin
            state_reg      <= IDLE;
            owner_id_reg   <= '0;
            owner_wr_reg   <= 1'b0;
            owner_addr_reg <= ADDRESS_BUS_BIT_WIDTH'(RESET_ADDRESS);
            rr_ptr_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            owner_id_reg   <= owner_id_next;
            owner_wr_reg   <= owner_wr_next;
            owner_addr_reg <= owner_addr_next;
            rr_ptr_reg     <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_id_next   = owner_id_reg;
        owner_wr_next   = owner_wr_reg;
        owner_addr_next = owner_addr_reg;
        rr_ptr_next     = rr_ptr_reg;
        take_grant      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    state_next = PHASE_0;
                    take_grant = 1'b1;
                end
            end
            PHASE_0: begin
                state_next = PHASE_1;
            end
            PHASE_1: begin
                if (any_valid) begin
                    state_next = PHASE_0;
                    take_grant = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Latch the winner so later changes on its inputs cannot disturb the access.
        if (take_grant) begin
            owner_id_next   = winner_id;
            owner_wr_next   = winner_wr;
            owner_addr_next = addr_acc[NUM_REQ-1];
            rr_ptr_next     = (winner_id == LAST_ID) ? '0 : winner_id + ID_ONE;
        end
    end

    assign in_access       = (state_reg == PHASE_0) || (state_reg == PHASE_1);
    assign bus.grant_o     = in_access ? owner_onehot : '0;
    assign bus.done_o      = (state_reg == PHASE_1) ? owner_onehot : '0;
    assign bus.mem_wr_en_o = in_access & owner_wr_reg;
    assign bus.mem_rd_en_o = in_access & ~owner_wr_reg;
    assign bus.address_o   = owner_addr_reg;
    assign bus.busy_o      = in_access;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter (NUM_REQ=4, 32-bit addresses).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point after each edge, one cycle per step.
module tb_memory_port_arbiter;

    logic clk;
    logic layer_reset;
    int   checks;
    int   errors;

    memory_port_arbiter_if #(.NUM_REQ(4), .ADDRESS_BUS_BIT_WIDTH(32)) bus ();

    memory_port_arbiter #(
        .NUM_REQ                (4),
        .REQ_ID_BIT_WIDTH       (2),
        .ADDRESS_BUS_BIT_WIDTH  (32),
        .MEMORY_STATE_BIT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .layer_reset (layer_reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output against the expected cycle.
    task automatic step(input string tag, input logic [3:0] g, input logic [3:0] d,
                        input logic rd, input logic wr, input logic [31:0] a,
                        input logic b);
        @(posedge clk);
        #1;
        check($sformatf("%s.grant", tag), 32'(bus.grant_o), 32'(g));
        check($sformatf("%s.done",  tag), 32'(bus.done_o), 32'(d));
        check($sformatf("%s.rd_en", tag), 32'(bus.mem_rd_en_o), 32'(rd));
        check($sformatf("%s.wr_en", tag), 32'(bus.mem_wr_en_o), 32'(wr));
        check($sformatf("%s.addr",  tag), bus.address_o, a);
        check($sformatf("%s.busy",  tag), 32'(bus.busy_o), 32'(b));
        $display("step %-12s grant=%b done=%b rd=%b wr=%b addr=%h busy=%b",
                 tag, bus.grant_o, bus.done_o, bus.mem_rd_en_o, bus.mem_wr_en_o,
                 bus.address_o, bus.busy_o);
    endtask

    task automatic set_addr(input int k, input logic [31:0] a);
        bus.req_address_i[k*32 +: 32] = a;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        layer_reset       = 1'b1;
        bus.req_i         = '0;
        bus.req_wr_i      = '0;
        bus.req_address_i = '0;

        // Reset state
        step("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        layer_reset = 1'b0;

        // Single read from requester 0
        set_addr(0, 32'h10);
        bus.req_i = 4'b0001;
        step("rd_p0",    4'b0001, 4'b0000, 1'b1, 1'b0, 32'h10, 1'b1);
        step("rd_p1",    4'b0001, 4'b0001, 1'b1, 1'b0, 32'h10, 1'b1);
        bus.req_i = 4'b0000;
        step("rd_idle",  4'b0000, 4'b0000, 1'b0, 1'b0, 32'h10, 1'b0);
        step("rd_idle2", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h10, 1'b0);

        // Four simultaneous writes from reset: order 0,1,2,3 back-to-back
        layer_reset = 1'b1;
        step("rst2", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        layer_reset = 1'b0;
        for (int k = 0; k < 4; k++) set_addr(k, 32'h100 + k);
        bus.req_wr_i = 4'b1111;
        bus.req_i    = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step($sformatf("wr4_p0_%0d", k), 4'(1 << k), 4'b0000, 1'b0, 1'b1, 32'h100 + k, 1'b1);
            step($sformatf("wr4_p1_%0d", k), 4'(1 << k), 4'(1 << k), 1'b0, 1'b1, 32'h100 + k, 1'b1);
            bus.req_i[k] = 1'b0;
        end
        step("wr4_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h103, 1'b0);

        // Pointer wrap: 3 served, then 0 and 3 together -> 0 first
        layer_reset = 1'b1;
        step("rst3", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        layer_reset  = 1'b0;
        bus.req_wr_i = 4'b0000;
        set_addr(0, 32'h40);
        set_addr(3, 32'h300);
        bus.req_i = 4'b1000;
        step("wrap_p0_3", 4'b1000, 4'b0000, 1'b1, 1'b0, 32'h300, 1'b1);
        step("wrap_p1_3", 4'b1000, 4'b1000, 1'b1, 1'b0, 32'h300, 1'b1);
        bus.req_i = 4'b0000;
        step("wrap_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h300, 1'b0);
        bus.req_i = 4'b1001;
        step("wrap_p0_0",  4'b0001, 4'b0000, 1'b1, 1'b0, 32'h40, 1'b1);
        step("wrap_p1_0",  4'b0001, 4'b0001, 1'b1, 1'b0, 32'h40, 1'b1);
        bus.req_i = 4'b1000;
        step("wrap_p0_3b", 4'b1000, 4'b0000, 1'b1, 1'b0, 32'h300, 1'b1);
        step("wrap_p1_3b", 4'b1000, 4'b1000, 1'b1, 1'b0, 32'h300, 1'b1);
        bus.req_i = 4'b0000;
        step("wrap_idle2", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h300, 1'b0);

        // Requester 2 (write) holds, requester 0 (read) re-requests: 2,0,2,0
        layer_reset = 1'b1;
        step("rst4", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        layer_reset  = 1'b0;
        set_addr(2, 32'h200);
        bus.req_wr_i = 4'b0100;
        bus.req_i    = 4'b0100;
        step("alt_p0_2a", 4'b0100, 4'b0000, 1'b0, 1'b1, 32'h200, 1'b1);
        bus.req_i = 4'b0101;
        step("alt_p1_2a", 4'b0100, 4'b0100, 1'b0, 1'b1, 32'h200, 1'b1);
        step("alt_p0_0a", 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h40,  1'b1);
        step("alt_p1_0a", 4'b0001, 4'b0001, 1'b1, 1'b0, 32'h40,  1'b1);
        step("alt_p0_2b", 4'b0100, 4'b0000, 1'b0, 1'b1, 32'h200, 1'b1);
        step("alt_p1_2b", 4'b0100, 4'b0100, 1'b0, 1'b1, 32'h200, 1'b1);
        bus.req_i = 4'b0001;
        step("alt_p0_0b", 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h40,  1'b1);
        step("alt_p1_0b", 4'b0001, 4'b0001, 1'b1, 1'b0, 32'h40,  1'b1);
        bus.req_i = 4'b0000;
        step("alt_idle",  4'b0000, 4'b0000, 1'b0, 1'b0, 32'h40,  1'b0);

        // Address change during PHASE_0 does not reach the memory
        layer_reset = 1'b1;
        step("rst5", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        layer_reset  = 1'b0;
        bus.req_wr_i = 4'b0000;
        set_addr(1, 32'h20);
        bus.req_i = 4'b0010;
        step("addr_p0", 4'b0010, 4'b0000, 1'b1, 1'b0, 32'h20, 1'b1);
        set_addr(1, 32'h30);
        step("addr_p1", 4'b0010, 4'b0010, 1'b1, 1'b0, 32'h20, 1'b1);
        bus.req_i = 4'b0000;
        step("addr_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h20, 1'b0);

        // Reset during PHASE_0 aborts the access and clears rr_ptr
        bus.req_i = 4'b0010;
        step("abort_p0", 4'b0010, 4'b0000, 1'b1, 1'b0, 32'h30, 1'b1);
        layer_reset = 1'b1;
        bus.req_i   = 4'b0000;
        step("abort_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        layer_reset = 1'b0;
        bus.req_i   = 4'b0011;
        step("abort_p0_0", 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h40, 1'b1);
        step("abort_p1_0", 4'b0001, 4'b0001, 1'b1, 1'b0, 32'h40, 1'b1);
        bus.req_i = 4'b0010;
        step("abort_p0_1", 4'b0010, 4'b0000, 1'b1, 1'b0, 32'h30, 1'b1);
        step("abort_p1_1", 4'b0010, 4'b0010, 1'b1, 1'b0, 32'h30, 1'b1);
        bus.req_i = 4'b0000;
        step("abort_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h30, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
